// File: rtl/loader_pkg.sv
// Shared types and constants for the pixel frame loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    HOLD,
    DRAIN
  } state_e;

  localparam int PIXEL_W_DEF = 8;
  localparam int FRAME_CNT_W = 16;

  typedef logic [PIXEL_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/pixel_frame_loader.sv
// Serial pixel stream -> registered parallel image buffer, held until acknowledged.
// Optional build macro PIXEL_BINARIZE_EN stores each pixel as all-ones/zero against THRESHOLD.
module pixel_frame_loader
  import loader_pkg::*;
#(
  parameter int NUM_PIXELS    = 784,
  parameter int PIXEL_W       = PIXEL_W_DEF,
  parameter int SETTLE_CYCLES = 4,
  parameter int THRESHOLD     = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_W-1:0]     s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [PIXEL_W-1:0]     pixels [NUM_PIXELS],
  output logic                   frame_valid,
  input  logic                   frame_ack,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int CNT_W = $clog2(NUM_PIXELS);
  localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

  if (NUM_PIXELS < 2 || THRESHOLD < 0 || THRESHOLD > (1 << PIXEL_W)) begin : g_bad_param
    $error("pixel_frame_loader: NUM_PIXELS or THRESHOLD out of range");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic                   ready_q, ready_d;
  logic                   fv_q, fv_d;
  logic                   err_q, err_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   beat, wr_en;
  logic [PIXEL_W-1:0]     wr_data;

  assign beat = s_valid && ready_q;

`ifdef PIXEL_BINARIZE_EN
  localparam logic [PIXEL_W:0] THR = (PIXEL_W + 1)'(THRESHOLD);
  assign wr_data = ({1'b0, s_data} >= THR) ? {PIXEL_W{1'b1}} : '0;
`else
  assign wr_data = s_data;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    settle_d = settle_q;
    fv_d     = fv_q;
    fcnt_d   = fcnt_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE: if (beat) begin
        wr_en = 1'b1;
        if (s_last) begin
          err_d   = 1'b1;
          count_d = '0;
        end else begin
          state_d = LOAD;
          count_d = CNT_W'(1);
        end
      end
      LOAD: if (beat) begin
        wr_en = 1'b1;
        if (count_q == LAST_IDX) begin
          if (s_last) begin
            state_d  = SETTLE;
            settle_d = SET_W'(SETTLE_CYCLES);
          end else begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end else if (s_last) begin
          err_d   = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = HOLD;
          fv_d    = 1'b1;
          fcnt_d  = fcnt_q + FRAME_CNT_W'(1);
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      HOLD: if (frame_ack) begin
        state_d = IDLE;
        fv_d    = 1'b0;
        count_d = '0;
      end
      // Tail of an overlong frame is swallowed without further errors.
      DRAIN: if (beat && s_last) begin
        state_d = IDLE;
        count_d = '0;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      settle_q <= '0;
      ready_q  <= 1'b0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      settle_q <= settle_d;
      ready_q  <= ready_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIXELS; i++) pixels[i] <= '0;
    end else if (wr_en) begin
      pixels[count_q] <= wr_data;
    end
  end

  assign s_ready     = ready_q;
  assign frame_valid = fv_q;
  assign frame_err   = err_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Randomized scoreboard bench for pixel_frame_loader (NUM_PIXELS=4, SETTLE_CYCLES=2).
module tb_pixel_frame_loader;
  import loader_pkg::*;

  localparam int NP     = 4;
  localparam int SETTLE = 2;

  typedef struct {
    logic [NP-1:0][7:0] pix;
    logic [15:0]        cnt;
    int                 cyc;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  pixels [NP];
  logic        frame_valid;
  logic        frame_ack = 1'b0;
  logic        frame_err;
  logic [15:0] frame_cnt;

  pixel_frame_loader #(
    .NUM_PIXELS(NP), .PIXEL_W(8), .SETTLE_CYCLES(SETTLE), .THRESHOLD(128)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .pixels(pixels), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  frm_t frame_q[$];
  int   err_q[$];
  logic [NP-1:0][7:0] model_pix = '0;
  logic [15:0]        model_cnt = '0;
  logic [7:0]         dbuf [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] stored(input logic [7:0] x);
`ifdef PIXEL_BINARIZE_EN
    return (x >= 8'd128) ? 8'hFF : 8'h00;
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] pix_word();
    logic [31:0] w;
    for (int i = 0; i < NP; i++) w[i*8 +: 8] = pixels[i];
    return w;
  endfunction

  // Monitor: pops expected frames / error pulses as the DUT presents them.
  initial begin
    frm_t hold_exp;
    logic prev_fv;
    int   e;
    prev_fv = 1'b0;
    hold_exp.pix = '0;
    hold_exp.cnt = '0;
    hold_exp.cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_fv = 1'b0;
      end else begin
        if (frame_err) begin
          if (err_q.size() == 0) chk("unexpected_frame_err", 1, 0);
          else begin
            e = err_q.pop_front();
            chk("frame_err_cycle", cyc, e);
          end
        end
        if (frame_valid && !prev_fv) begin
          if (frame_q.size() == 0) chk("unexpected_frame_valid", 1, 0);
          else begin
            hold_exp = frame_q.pop_front();
            chk("frame_valid_latency", cyc, hold_exp.cyc);
            chk("frame_cnt", frame_cnt, hold_exp.cnt);
          end
        end
        if (frame_valid) begin
          chk("pixels_hold", pix_word(), hold_exp.pix);
          chk("s_ready_in_hold", s_ready, 0);
        end
        prev_fv = frame_valid;
      end
    end
  end

  // gap: 0 back-to-back, 1 idle cycle between beats, 2 random idles
  task automatic send_frame(input int len, input int gap);
    int c, budget;
    for (int i = 0; i < len; i++) begin
      int idles;
      idles = (i == 0) ? 0 : (gap == 1) ? 1 : (gap == 2) ? $urandom_range(0, 2) : 0;
      repeat (idles) begin
        @(negedge clk);
        s_valid = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = dbuf[i];
      s_last  = (i == len - 1);
      budget  = 20;
      while (!s_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!s_ready) begin
        chk("s_ready_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      c = cyc;
      @(posedge clk);
      if (i < NP) model_pix[i] = stored(dbuf[i]);
      if (len == NP && i == len - 1) begin
        model_cnt++;
        frame_q.push_back('{pix: model_pix, cnt: model_cnt, cyc: c + SETTLE + 2});
      end
      if (len < NP && i == len - 1) err_q.push_back(c + 1);
      if (len > NP && i == NP - 1) err_q.push_back(c + 1);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_and_ack();
    int budget;
    budget = 20;
    while (!frame_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!frame_valid) begin
      chk("frame_valid_timeout", 0, 1);
      return;
    end
    // Hammer the input while held: nothing may be written.
    repeat ($urandom_range(0, 3)) begin
      s_valid = 1'b1;
      s_data  = 8'h55;
      s_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    s_valid   = 1'b1;
    s_data    = 8'h55;
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    chk("frame_valid_after_ack", frame_valid, 0);
    chk("s_ready_after_ack", s_ready, 1);
  endtask

  task automatic load4(input logic [7:0] a, b, c, d);
    dbuf[0] = a; dbuf[1] = b; dbuf[2] = c; dbuf[3] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_pixels", pix_word(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_rst", s_ready, 1);

    load4(8'h11, 8'h22, 8'h33, 8'h44);
    send_frame(4, 0);
    wait_and_ack();

    dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
    send_frame(2, 0);
    load4(8'h01, 8'h02, 8'h03, 8'h04);
    send_frame(4, 0);
    wait_and_ack();

    load4(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    dbuf[4] = 8'hC5;
    send_frame(5, 0);
    load4(8'h09, 8'h08, 8'h07, 8'h06);
    send_frame(4, 1);
    wait_and_ack();

    load4(8'hE0, 8'hE1, 8'hE2, 8'hE3);
    send_frame(2, 0);
    err_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_pixels", pix_word(), 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_s_ready", s_ready, 0);
    model_pix = '0;
    model_cnt = '0;
    @(negedge clk);
    chk("midrst_no_err", frame_err, 0);
    rst = 1'b0;
    @(negedge clk);
    load4(8'd127, 8'd128, 8'd0, 8'd255);
    send_frame(4, 0);
    wait_and_ack();

    for (int f = 0; f < 30; f++) begin
      int kind, len;
      kind = $urandom_range(0, 2);
      len  = (kind == 0) ? $urandom_range(2, NP - 1) : (kind == 1) ? NP : $urandom_range(NP + 1, 7);
      for (int i = 0; i < 8; i++) dbuf[i] = 8'($urandom);
      send_frame(len, $urandom_range(0, 2));
      if (len == NP) wait_and_ack();
    end

    repeat (8) @(negedge clk);
    chk("frames_outstanding", frame_q.size(), 0);
    chk("errs_outstanding", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
Upstream feeder for the digit-classifier network. It accepts a serial byte stream of 8-bit pixels, for example from the UART receiver, using a valid/ready/last handshake. It assembles one full image into a registered buffer and presents it as the parallel pixel array that drives the network's input layer. After a programmable settle delay for the combinational network, it asserts frame_valid and holds the image stable until the result consumer acknowledges it.

Parameters:
NUM_PIXELS, 784, pixels per frame (must be >= 2); equals the network's first-layer width
PIXEL_W, 8, bits per pixel
SETTLE_CYCLES, 4, cycles between frame completion and frame_valid (0 allowed), covering network combinational delay
THRESHOLD, 128, binarize threshold; used only when PIXEL_BINARIZE_EN is defined

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
s_data  in  PIXEL_W  incoming pixel byte
s_valid  in  1  s_data valid
s_last  in  1  marks final pixel of a frame; qualified by s_valid
s_ready  out  1  loader can accept a beat (registered)
pixels  out  PIXEL_W x NUM_PIXELS  unpacked array, registered image buffer, to network inputs
frame_valid  out  1  pixels hold a complete, settled frame
frame_ack  in  1  consumer done; releases the buffer
frame_err  out  1  one-cycle pulse on a malformed frame
frame_cnt  out  16  count of good frames, wraps at 65535->0

Behaviour:
- Reset (async, rst=1) values:
  - State: IDLE.
  - Counters: beat count 0, settle count 0.
  - Outputs: all pixels 0, s_ready 0, frame_valid 0, frame_err 0, frame_cnt 0.
  - First rising edge after rst deasserts sets s_ready 1.
- A beat transfers when s_valid && s_ready on a rising edge. The beat writes pixels[count] and increments count. Beats are never written while s_ready=0.
- States: IDLE, LOAD, SETTLE, HOLD, DRAIN.
- IDLE:
  - s_ready=1.
  - First beat goes to LOAD with count=1.
  - A beat with s_last in IDLE raises frame_err, stays in IDLE, count=0.
- LOAD:
  - Beat with s_last and count==NUM_PIXELS-1 (good frame): write it, s_ready->0, go to SETTLE, load settle counter with SETTLE_CYCLES.
  - Beat with s_last and count<NUM_PIXELS-1 (short frame): write it, frame_err pulse, count->0, go to IDLE, s_ready stays 1.
  - Beat at count==NUM_PIXELS-1 without s_last (long frame): write it, frame_err pulse, go to DRAIN.
- DRAIN:
  - s_ready=1; beats are discarded (no writes).
  - Beat with s_last: go to IDLE, count->0. No second frame_err.
- SETTLE:
  - Counter decrements each cycle; s_ready=0.
  - At 0: go to HOLD, frame_valid->1, frame_cnt+1 in the same cycle.
  - With SETTLE_CYCLES=0: frame_valid rises the cycle after the last beat (1-cycle latency).
  - With SETTLE_CYCLES=N: latency is N+1 cycles.
- HOLD:
  - frame_valid=1; pixels are guaranteed stable.
  - frame_ack sampled high: next cycle frame_valid=0, s_ready=1, count=0, state IDLE.
  - frame_ack is ignored outside HOLD.
  - pixels keep their old contents until overwritten beat-by-beat.
- frame_err is a single-cycle pulse, registered, one cycle after the offending beat.
- rst asserted mid-frame or mid-HOLD aborts immediately to reset values. The partial frame is lost, and no frame_err is raised.

Optional Feature:
PIXEL_BINARIZE_EN
- Defined: each stored pixel is written as {PIXEL_W{1'b1}} if s_data >= THRESHOLD, else 0.
- Undefined: s_data is stored unmodified; THRESHOLD is unused.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package loader_pkg holds:
  - state enum typedef (IDLE, LOAD, SETTLE, HOLD, DRAIN)
  - PIXEL_W default
  - pixel_t typedef
  - frame count width constant (16)
- Count width is derived locally as $clog2(NUM_PIXELS).
- No sub-module; the settle counter and beat counter stay inline.

Test Plan:
All scenarios use NUM_PIXELS=4, SETTLE_CYCLES=2, and assume the first cycle after reset.
- Good frame: beats 0x11,0x22,0x33,0x44 with last on the 4th -> frame_valid rises 3 cycles after the 4th beat; pixels={11,22,33,44}; frame_cnt=1; s_ready=0 until ack; ack -> s_ready=1 next cycle.
- Short frame: 0xAA,0xBB(last) -> frame_err pulses once, frame_valid stays 0; next good frame 1,2,3,4 loads correctly.
- Long frame: 5 beats, last on the 5th -> frame_err pulses after the 4th beat; 5th beat discarded; next good frame accepted; frame_cnt increments only once.
- Backpressure: s_valid held high through SETTLE/HOLD with data 0x55 -> no write, pixels unchanged until ack; s_valid toggled each cycle during LOAD -> exactly 4 writes.
- Reset mid-load: rst after 2 beats -> pixels all 0, frame_cnt 0, s_ready 0 during rst; a following good frame completes normally.
- PIXEL_BINARIZE_EN build: beats 127,128,0,255 -> pixels {0,255,0,255}.
